cond_unit: RTL and testbench
============================

COND_UNIT -- requirements
Module: cond_unit

Interface
REQ-001 CNT_WIDTH, default 16: width of the two instruction statistics counters.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising edge of clk.
REQ-004 valid_in  input  1  an instruction is present in Execute this cycle.
REQ-005 stall  input  1  Execute held; instruction not consumed this cycle.
REQ-006 Cond  input  4  instruction condition field, ARM encoding.
REQ-007 ALUFlags  input  4  {N,Z,C,V} from the ALU for the current instruction.
REQ-008 FlagW  input  2  [1] requests N,Z update; [0] requests C,V update.
REQ-009 PCS, RegW, MemW, NoWrite  input  1 each  decoder write/branch requests; NoWrite suppresses the register write (CMP/TST).
REQ-010 clr_cnt  input  1  synchronous clear of both counters.
REQ-011 PCSrc, RegWrite, MemWrite  output  1 each  gated write/branch enables.
REQ-012 CondEx  output  1  condition passed for the current instruction.
REQ-013 Flags  output  4  architectural {N,Z,C,V} register.
REQ-014 execCount, squashCount  output  CNT_WIDTH each  executed / squashed instruction counts.

Function
REQ-015 Flags, execCount, squashCount SHALL be registers; all other outputs SHALL be combinational from inputs and Flags (zero-cycle latency).
REQ-016 CondEx SHALL be evaluated from registered Flags (never ALUFlags): 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL 1; 1111 0.
REQ-017 Define fire = valid_in & !stall & CondEx.
REQ-018 PCSrc SHALL equal PCS & fire.
REQ-019 RegWrite SHALL equal RegW & !NoWrite & fire.
REQ-020 MemWrite SHALL equal MemW & fire.
REQ-021 On fire & FlagW[1], Flags[3:2] SHALL load ALUFlags[3:2] at the next edge.
REQ-022 On fire & FlagW[0], Flags[1:0] SHALL load ALUFlags[1:0] at the next edge.
REQ-023 Flag fields not selected by FlagW, or any cycle without fire, SHALL hold.
REQ-024 Flags updated by instruction k SHALL first affect CondEx of the instruction presented in the following cycle; no same-cycle bypass.
REQ-025 When valid_in & !stall: execCount SHALL increment if CondEx=1, else squashCount SHALL increment; exactly one counter moves per consumed instruction.
REQ-026 stall=1 or valid_in=0: no counter increments, no flag update, all gated outputs 0.
REQ-027 Counters SHALL saturate at 2^CNT_WIDTH-1, no wrap-around.
REQ-028 clr_cnt=1 SHALL zero both counters at next edge; clear wins over a simultaneous increment; flags unaffected.
REQ-029 Unconditional encoding 1111 SHALL count as squashed.

Reset
REQ-030 rst_n=0 at a rising edge SHALL set Flags=0000, execCount=0, squashCount=0, overriding clr_cnt, fire and any flag update that cycle.
REQ-031 During reset cycle, combinational outputs SHALL still follow REQ-016..020 using Flags as currently held; after release, Flags=0000, so EQ fails and NE passes.
REQ-032 Reset asserted mid-sequence SHALL discard the in-flight instruction's flag update and count.

Verification
REQ-033 Reset, then valid_in=1, Cond=0000 (EQ), RegW=1 -> CondEx=0, RegWrite=0, squashCount=1 next cycle.
REQ-034 Cycle 1: Cond=1110, FlagW=11, ALUFlags=0100 (CMP equal, NoWrite=1) -> RegWrite=0, Flags=0100 after edge; cycle 2: Cond=0000, PCS=1 -> PCSrc=1, execCount=2.
REQ-035 Flags=0000, Cond=1110, FlagW=10, ALUFlags=1011 -> Flags=1000 after edge (C,V held).
REQ-036 stall=1 with Cond=1110, FlagW=11, MemW=1, ALUFlags=1111 -> MemWrite=0, Flags and counters unchanged.
REQ-037 CNT_WIDTH=4, issue 17 AL instructions -> execCount saturates at 15; then clr_cnt=1 with valid AL instruction same cycle -> both counters 0.
REQ-038 Flags=1001 (N=1,V=1), sweep Cond 1010/1011/1100/1101 -> CondEx 1/0/1/0.

Source files
------------

// File: rtl/cond_unit.sv
// Conditional-execution unit: evaluates ARM condition codes against the held flags,
// gates write/branch enables, updates NZCV and keeps saturating executed/squashed counts.
module cond_unit #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 valid_in,
    input  logic                 stall,
    input  logic [3:0]           Cond,
    input  logic [3:0]           ALUFlags,
    input  logic [1:0]           FlagW,
    input  logic                 PCS,
    input  logic                 RegW,
    input  logic                 MemW,
    input  logic                 NoWrite,
    input  logic                 clr_cnt,
    output logic                 PCSrc,
    output logic                 RegWrite,
    output logic                 MemWrite,
    output logic                 CondEx,
    output logic [3:0]           Flags,
    output logic [CNT_WIDTH-1:0] execCount,
    output logic [CNT_WIDTH-1:0] squashCount
);

    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic n_flag, z_flag, c_flag, v_flag;
    logic consumed, fire;

    assign {n_flag, z_flag, c_flag, v_flag} = Flags;

    // Condition uses only the registered flags: no bypass from the current ALU result.
    always_comb begin
        CondEx = 1'b0;
        unique case (Cond)
            4'b0000: CondEx = z_flag;
            4'b0001: CondEx = ~z_flag;
            4'b0010: CondEx = c_flag;
            4'b0011: CondEx = ~c_flag;
            4'b0100: CondEx = n_flag;
            4'b0101: CondEx = ~n_flag;
            4'b0110: CondEx = v_flag;
            4'b0111: CondEx = ~v_flag;
            4'b1000: CondEx = c_flag & ~z_flag;
            4'b1001: CondEx = ~c_flag | z_flag;
            4'b1010: CondEx = (n_flag == v_flag);
            4'b1011: CondEx = (n_flag != v_flag);
            4'b1100: CondEx = ~z_flag & (n_flag == v_flag);
            4'b1101: CondEx = z_flag | (n_flag != v_flag);
            4'b1110: CondEx = 1'b1;
            4'b1111: CondEx = 1'b0;
            default: CondEx = 1'b0;
        endcase
    end

    assign consumed = valid_in & ~stall;
    assign fire     = consumed & CondEx;

    assign PCSrc    = PCS & fire;
    assign RegWrite = RegW & ~NoWrite & fire;
    assign MemWrite = MemW & fire;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            Flags <= 4'b0000;
        end else if (fire) begin
            if (FlagW[1]) Flags[3:2] <= ALUFlags[3:2];
            if (FlagW[0]) Flags[1:0] <= ALUFlags[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || clr_cnt) begin
            execCount   <= '0;
            squashCount <= '0;
        end else if (consumed) begin
            if (CondEx) begin
                if (execCount != CntMax) execCount <= execCount + 1'b1;
            end else begin
                if (squashCount != CntMax) squashCount <= squashCount + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// Directed self-checking bench for cond_unit (counters narrowed to 4 bits to reach saturation).
module tb_cond_unit;

    localparam int unsigned W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid_in, stall;
    logic [3:0]   Cond, ALUFlags;
    logic [1:0]   FlagW;
    logic         PCS, RegW, MemW, NoWrite, clr_cnt;
    logic         PCSrc, RegWrite, MemWrite, CondEx;
    logic [3:0]   Flags;
    logic [W-1:0] execCount, squashCount;

    int checks = 0;
    int errors = 0;

    cond_unit #(.CNT_WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .stall(stall),
        .Cond(Cond), .ALUFlags(ALUFlags), .FlagW(FlagW), .PCS(PCS), .RegW(RegW),
        .MemW(MemW), .NoWrite(NoWrite), .clr_cnt(clr_cnt), .PCSrc(PCSrc),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .CondEx(CondEx), .Flags(Flags),
        .execCount(execCount), .squashCount(squashCount)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        valid_in = 0; stall = 0; Cond = 4'b1110; ALUFlags = 0; FlagW = 0;
        PCS = 0; RegW = 0; MemW = 0; NoWrite = 0; clr_cnt = 0;
    endtask

    // Inputs change on negedge; combinational outputs sampled #1 later, state #1 after posedge.
    task automatic edge_then_sample();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        clr_cnt = 1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", 16'(Flags), 16'h0);
        check("reset_exec", 16'(execCount), 16'h0);
        check("reset_squash", 16'(squashCount), 16'h0);

        // EQ fails on cleared flags -> squashed
        @(negedge clk);
        idle_inputs(); rst_n = 1;
        valid_in = 1; Cond = 4'b0000; RegW = 1;
        #1;
        check("eq_condex", 16'(CondEx), 16'h0);
        check("eq_regwrite", 16'(RegWrite), 16'h0);
        edge_then_sample();
        check("eq_squash", 16'(squashCount), 16'h1);
        check("eq_exec", 16'(execCount), 16'h0);

        // CMP equal: AL, NoWrite, sets Z
        @(negedge clk);
        Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b0100; NoWrite = 1; RegW = 1;
        #1;
        check("cmp_condex", 16'(CondEx), 16'h1);
        check("cmp_regwrite", 16'(RegWrite), 16'h0);
        edge_then_sample();
        check("cmp_flags", 16'(Flags), 16'h4);
        check("cmp_exec", 16'(execCount), 16'h1);

        // BEQ now taken
        @(negedge clk);
        Cond = 4'b0000; PCS = 1; FlagW = 0; NoWrite = 0; RegW = 0;
        #1;
        check("beq_pcsrc", 16'(PCSrc), 16'h1);
        edge_then_sample();
        check("beq_exec", 16'(execCount), 16'h2);
        check("beq_squash", 16'(squashCount), 16'h1);

        // NE with Z=1 held: ALUFlags Z=0 must not bypass
        @(negedge clk);
        PCS = 0; Cond = 4'b0001; FlagW = 2'b11; ALUFlags = 4'b0000; RegW = 1;
        #1;
        check("nobypass_condex", 16'(CondEx), 16'h0);
        check("nobypass_regwrite", 16'(RegWrite), 16'h0);
        edge_then_sample();
        check("nobypass_flags", 16'(Flags), 16'h4);
        check("nobypass_squash", 16'(squashCount), 16'h2);

        // Reset mid-sequence discards in-flight update/count; combos still live
        @(negedge clk);
        idle_inputs(); rst_n = 0;
        valid_in = 1; Cond = 4'b1110; FlagW = 2'b11; ALUFlags = 4'b1111; MemW = 1;
        #1;
        check("rst_condex", 16'(CondEx), 16'h1);
        check("rst_memwrite", 16'(MemWrite), 16'h1);
        edge_then_sample();
        check("rst_flags", 16'(Flags), 16'h0);
        check("rst_exec", 16'(execCount), 16'h0);
        check("rst_squash", 16'(squashCount), 16'h0);

        @(negedge clk);
        idle_inputs(); rst_n = 1;
        Cond = 4'b0000;
        #1;
        check("post_rst_eq", 16'(CondEx), 16'h0);
        Cond = 4'b0001;
        #1;
        check("post_rst_ne", 16'(CondEx), 16'h1);

        // Only N,Z written
        @(negedge clk);
        valid_in = 1; Cond = 4'b1110; FlagW = 2'b10; ALUFlags = 4'b1011;
        edge_then_sample();
        check("nz_only_flags", 16'(Flags), 16'h8);
        check("nz_only_exec", 16'(execCount), 16'h1);

        // Stall blocks everything
        @(negedge clk);
        stall = 1; FlagW = 2'b11; MemW = 1; ALUFlags = 4'b1111;
        #1;
        check("stall_memwrite", 16'(MemWrite), 16'h0);
        edge_then_sample();
        check("stall_flags", 16'(Flags), 16'h8);
        check("stall_exec", 16'(execCount), 16'h1);
        check("stall_squash", 16'(squashCount), 16'h0);

        @(negedge clk);
        stall = 0; FlagW = 2'b00;
        #1;
        check("store_memwrite", 16'(MemWrite), 16'h1);
        edge_then_sample();
        check("store_exec", 16'(execCount), 16'h2);

        // Flags = 1001 (N=1, C=0, Z=0, V=1)
        @(negedge clk);
        MemW = 0; FlagW = 2'b11; ALUFlags = 4'b1001;
        edge_then_sample();
        check("set1001_flags", 16'(Flags), 16'h9);
        check("set1001_exec", 16'(execCount), 16'h3);

        @(negedge clk);
        idle_inputs();
        Cond = 4'b1010; #1; check("ge", 16'(CondEx), 16'h1);
        Cond = 4'b1011; #1; check("lt", 16'(CondEx), 16'h0);
        Cond = 4'b1100; #1; check("gt", 16'(CondEx), 16'h1);
        Cond = 4'b1101; #1; check("le", 16'(CondEx), 16'h0);
        Cond = 4'b1000; #1; check("hi", 16'(CondEx), 16'h0);
        Cond = 4'b1001; #1; check("ls", 16'(CondEx), 16'h1);
        Cond = 4'b0110; #1; check("vs", 16'(CondEx), 16'h1);
        Cond = 4'b0101; #1; check("pl", 16'(CondEx), 16'h0);
        Cond = 4'b1111; #1; check("nv", 16'(CondEx), 16'h0);

        // 1111 consumed counts as squashed
        valid_in = 1; RegW = 1;
        #1;
        check("nv_regwrite", 16'(RegWrite), 16'h0);
        edge_then_sample();
        check("nv_squash", 16'(squashCount), 16'h1);
        check("nv_exec", 16'(execCount), 16'h3);

        // 17 AL instructions: exec 3 -> saturates at 15
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            idle_inputs();
            valid_in = 1; Cond = 4'b1110;
        end
        edge_then_sample();
        check("sat_exec", 16'(execCount), 16'hF);
        check("sat_squash", 16'(squashCount), 16'h1);

        // Clear beats a simultaneous increment; flags untouched
        @(negedge clk);
        clr_cnt = 1; valid_in = 1; Cond = 4'b1110;
        edge_then_sample();
        check("clr_exec", 16'(execCount), 16'h0);
        check("clr_squash", 16'(squashCount), 16'h0);
        check("clr_flags", 16'(Flags), 16'h9);

        @(negedge clk);
        idle_inputs();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
